// File: rtl/clk_en_gen.sv
// Fractional NUM/DEN clock-enable generator with settle/lock state machine.
// Optional square-wave outputs o_sq are enabled by defining CLK_EN_GEN_SQUARE_EN.
module clk_en_gen #(
  parameter int CHANNELS      = 2,
  parameter int W             = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int DEF_NUM       = 1,
  parameter int DEF_DEN       = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [CHANNELS*W-1:0] i_num,
  input  logic [CHANNELS*W-1:0] i_den,
  input  logic                  i_load,
  output logic [CHANNELS-1:0]   o_en,
  output logic [CHANNELS-1:0]   o_err,
`ifdef CLK_EN_GEN_SQUARE_EN
  output logic [CHANNELS-1:0]   o_sq,
`endif
  output logic                  o_locked
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic DEF_BAD = (DEF_DEN == 0) || (DEF_NUM > DEF_DEN);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_SETTLE,
    ST_RUN
  } state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [CHANNELS-1:0][W-1:0]  num_q, num_d;
  logic [CHANNELS-1:0][W-1:0]  den_q, den_d;
  logic [CHANNELS-1:0][W-1:0]  acc_q, acc_d;
  logic [CHANNELS-1:0]         en_q, en_d;
  logic [CHANNELS-1:0]         err_q, err_d;
  logic                        locked_q, locked_d;
  logic [W:0]                  sum;
`ifdef CLK_EN_GEN_SQUARE_EN
  logic [CHANNELS-1:0]         sq_q, sq_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    den_d   = den_q;
    acc_d   = acc_q;
    en_d    = '0;
    err_d   = '0;
    sum     = '0;
`ifdef CLK_EN_GEN_SQUARE_EN
    sq_d    = '0;
`endif

    case (state_q)
      ST_RESET: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) state_d = ST_RUN;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_RUN;
    endcase

    if (i_load) begin
      num_d   = i_num;
      den_d   = i_den;
      state_d = ST_SETTLE;
      cnt_d   = '0;
    end

    // Accumulators only advance on a RUN cycle with no load pending; a load
    // clears them in the same edge that drops the enables.
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      err_d[c] = (den_d[c] == '0) || (num_d[c] > den_d[c]);
      acc_d[c] = '0;
      if (state_q == ST_RUN && !i_load && !err_d[c]) begin
        sum = {1'b0, acc_q[c]} + {1'b0, num_q[c]};
        if (sum >= {1'b0, den_q[c]}) begin
          acc_d[c] = W'(sum - {1'b0, den_q[c]});
          en_d[c]  = 1'b1;
        end else begin
          acc_d[c] = sum[W-1:0];
        end
`ifdef CLK_EN_GEN_SQUARE_EN
        sq_d[c] = sq_q[c] ^ en_d[c];
`endif
      end
    end

    locked_d = (state_d == ST_RUN);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      num_q    <= {CHANNELS{W'(DEF_NUM)}};
      den_q    <= {CHANNELS{W'(DEF_DEN)}};
      acc_q    <= '0;
      en_q     <= '0;
      err_q    <= {CHANNELS{DEF_BAD}};
      locked_q <= 1'b0;
`ifdef CLK_EN_GEN_SQUARE_EN
      sq_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      den_q    <= den_d;
      acc_q    <= acc_d;
      en_q     <= en_d;
      err_q    <= err_d;
      locked_q <= locked_d;
`ifdef CLK_EN_GEN_SQUARE_EN
      sq_q     <= sq_d;
`endif
    end
  end

  assign o_en     = en_q;
  assign o_err    = err_q;
  assign o_locked = locked_q;
`ifdef CLK_EN_GEN_SQUARE_EN
  assign o_sq     = sq_q;
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen (CHANNELS=2, W=8, SETTLE_CYCLES=16, defaults 1/5).
module tb_clk_en_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] num = '0;
  logic [15:0] den = '0;
  logic        load = 1'b0;
  logic [1:0]  en;
  logic [1:0]  err;
  logic        locked;
`ifdef CLK_EN_GEN_SQUARE_EN
  logic [1:0]  sq;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  clk_en_gen #(
    .CHANNELS(2), .W(8), .SETTLE_CYCLES(16), .DEF_NUM(1), .DEF_DEN(5)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_num(num), .i_den(den), .i_load(load),
    .o_en(en), .o_err(err),
`ifdef CLK_EN_GEN_SQUARE_EN
    .o_sq(sq),
`endif
    .o_locked(locked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses the load strobe for one edge (L) and checks the state right after L.
  task automatic do_load(input string nm, input logic [7:0] n0, input logic [7:0] d0,
                         input logic [7:0] n1, input logic [7:0] d1, input logic [1:0] exp_err);
    num  = {n1, n0};
    den  = {d1, d0};
    load = 1'b1;
    tick();
    load = 1'b0;
    n_checks++;
    if (locked !== 1'b0 || en !== 2'b00) $display("FAIL %s_drop locked=%b en=%b required locked=0 en=00", nm, locked, en);
    else n_pass++;
    n_checks++;
    if (err !== exp_err) $display("FAIL %s_err got=%b required=%b", nm, err, exp_err);
    else n_pass++;
  endtask

  task automatic wait_lock(input string nm, input int exp_n);
    int n = 0;
    while (locked !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    n_checks++;
    if (n !== exp_n) $display("FAIL %s_lock edges=%0d required=%0d", nm, n, exp_n);
    else n_pass++;
  endtask

  // Period p: strobe on every p-th RUN cycle; p==0 means never.
  task automatic run_period(input string nm, input int p0, input int p1, input int cycles);
    int bad = 0;
    logic [1:0] exp;
    for (int k = 1; k <= cycles; k++) begin
      tick();
      exp[0] = (p0 != 0) && (k % p0 == 0);
      exp[1] = (p1 != 0) && (k % p1 == 0);
      if (en !== exp) begin
        if (bad == 0) $display("FAIL %s_pattern cycle=%0d en=%b required=%b", nm, k, en, exp);
        bad++;
      end
    end
    n_checks++;
    if (bad == 0) n_pass++;
  endtask

  task automatic count_pulses(input string nm, input int cycles, input int exp0, input int exp1);
    int c0 = 0;
    int c1 = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (en[0] === 1'b1) c0++;
      if (en[1] === 1'b1) c1++;
    end
    n_checks++;
    if (c0 !== exp0) $display("FAIL %s_count0 got=%0d required=%0d", nm, c0, exp0);
    else n_pass++;
    n_checks++;
    if (c1 !== exp1) $display("FAIL %s_count1 got=%0d required=%0d", nm, c1, exp1);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (en !== 2'b00 || locked !== 1'b0) $display("FAIL reset_out en=%b locked=%b required en=00 locked=0", en, locked);
    else n_pass++;
    n_checks++;
    if (err !== 2'b00) $display("FAIL reset_err got=%b required=00", err);
    else n_pass++;
    rst = 1'b0;
    wait_lock("reset", 17);
    run_period("default_1_5", 5, 5, 20);
    count_pulses("default_1000", 1000, 200, 200);
  endtask

  task automatic test_fractional();
    int bad = 0;
    logic [1:0] exp;
    do_load("frac", 8'd2, 8'd5, 8'd5, 8'd5, 2'b00);
    wait_lock("frac", 16);
    // 2/5 from a zero accumulator strobes at RUN cycles 3,5,8,10,...
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp = {1'b1, (k % 5 == 3) || (k % 5 == 0)};
      if (en !== exp) begin
        if (bad == 0) $display("FAIL frac_pattern cycle=%0d en=%b required=%b", k, en, exp);
        bad++;
      end
    end
    n_checks++;
    if (bad == 0) n_pass++;
    count_pulses("frac_1000", 1000, 400, 1000);
  endtask

  task automatic test_invalid();
    do_load("invalid", 8'd3, 8'd0, 8'd6, 8'd5, 2'b11);
    wait_lock("invalid", 16);
    run_period("invalid_quiet", 0, 0, 50);
    n_checks++;
    if (err !== 2'b11) $display("FAIL invalid_err_hold got=%b required=11", err);
    else n_pass++;
    do_load("reload", 8'd1, 8'd5, 8'd1, 8'd5, 2'b00);
    wait_lock("reload", 16);
    run_period("reload_1_5", 5, 5, 10);
  endtask

  task automatic test_mid_run();
    for (int k = 0; k < 7; k++) tick();
    do_load("mid", 8'd1, 8'd2, 8'd1, 8'd3, 2'b00);
    wait_lock("mid", 16);
    run_period("mid_new", 2, 3, 12);
  endtask

  task automatic test_load_with_reset();
    num  = {8'd1, 8'd2, 8'd3, 8'd0};
    num  = {8'd1, 8'd3};
    den  = {8'd2, 8'd0};
    rst  = 1'b1;
    load = 1'b1;
    tick();
    rst  = 1'b0;
    load = 1'b0;
    n_checks++;
    if (err !== 2'b00 || locked !== 1'b0) $display("FAIL rst_load_state err=%b locked=%b required err=00 locked=0", err, locked);
    else n_pass++;
    wait_lock("rst_load", 17);
    run_period("rst_load_1_5", 5, 5, 20);
  endtask

  task automatic test_edge_ratios();
    do_load("zero", 8'd0, 8'd5, 8'd0, 8'd5, 2'b00);
    wait_lock("zero", 16);
    count_pulses("zero_1000", 1000, 0, 0);
    do_load("full", 8'd255, 8'd255, 8'd255, 8'd255, 2'b00);
    wait_lock("full", 16);
    count_pulses("full_1000", 1000, 1000, 1000);
  endtask

`ifdef CLK_EN_GEN_SQUARE_EN
  task automatic test_square();
    int bad = 0;
    logic [1:0] exp;
    do_load("square", 8'd1, 8'd5, 8'd1, 8'd5, 2'b00);
    for (int k = 0; k < 16; k++) begin
      if (sq !== 2'b00 && bad == 0) begin
        $display("FAIL square_settle sq=%b required=00", sq);
        bad++;
      end
      tick();
    end
    n_checks++;
    if (bad == 0) n_pass++;
    n_checks++;
    if (locked !== 1'b1) $display("FAIL square_lock locked=%b required=1", locked);
    else n_pass++;
    bad = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp = ((k / 5) % 2 == 1) ? 2'b11 : 2'b00;
      if (sq !== exp) begin
        if (bad == 0) $display("FAIL square_wave cycle=%0d sq=%b required=%b", k, sq, exp);
        bad++;
      end
    end
    n_checks++;
    if (bad == 0) n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_fractional();
    test_invalid();
    test_mid_run();
    test_load_with_reset();
    test_edge_ratios();
`ifdef CLK_EN_GEN_SQUARE_EN
    test_square();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
